// File: rtl/memory_stage_module.sv
// memory_stage_module
//   Memory stage of the unhazarded pipeline, sitting directly after execute.
//   It holds a word-organised data memory, performs stores and loads using
//   the execute-stage outputs, registers the M/W boundary and drives the
//   writeback result mux toward the register file.
//
//   Handshake: there is none. Every cycle is a valid slot; the M inputs are
//   consumed on every rising edge and appear on the W outputs one cycle
//   later. All-zero control inputs behave as a NOP.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset (clears W registers and memory)
//   RegWriteM   register-write enable from execute
//   ResultSrcM  1 = load result, 0 = ALU result
//   MemWriteM   store enable
//   ALUResultM  byte address / ALU result
//   WriteDataM  store data
//   RdM         destination register
//   PCPlus4M    PC+4 passthrough
//   RegWriteW   registered write enable, dropped on a faulted load
//   ResultSrcW  registered ResultSrc
//   ReadDataW   registered load data
//   ALUResultW  registered ALU result
//   RdW         registered destination register
//   PCPlus4W    registered PC+4
//   ResultW     combinational writeback value
//   MemFaultW   registered access-fault flag
module memory_stage_module #(
  parameter int DMEM_DEPTH = 1024,
  localparam int ADDR_BITS = $clog2(DMEM_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ResultW,
  output logic        MemFaultW
);

  logic [31:0] mem [DMEM_DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic                 aligned;
  logic                 inrange;
  logic                 ok;
  logic [31:0]          ReadDataM;
  logic                 faultM;

  // Address decode: the byte offset only matters for the alignment check,
  // and any bit above the word index makes the access out of range.
  always_comb begin
    idx       = ALUResultM[ADDR_BITS+1:2];
    aligned   = (ALUResultM[1:0] == 2'b00);
    inrange   = (ALUResultM[31:ADDR_BITS+2] == '0);
    ok        = aligned & inrange;
    // Asynchronous read; a bad address reads as zero so ReadDataW is clean.
    ReadDataM = ok ? mem[idx] : 32'h0;
    // Only memory operations can fault; plain ALU ops use any address.
    faultM    = (MemWriteM | ResultSrcM) & ~ok;
  end

  // Data memory. The write lands on the same edge that samples ReadDataM into
  // ReadDataW, so a same-cycle load of the written word returns old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (MemWriteM && ok) begin
      mem[idx] <= WriteDataM;
    end
  end

  // M/W pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      ReadDataW  <= 32'h0;
      ALUResultW <= 32'h0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'h0;
      MemFaultW  <= 1'b0;
    end else begin
      // A faulted load must not write garbage back to the register file.
      RegWriteW  <= RegWriteM & ~(ResultSrcM & ~ok);
      ResultSrcW <= ResultSrcM;
      ReadDataW  <= ReadDataM;
      ALUResultW <= ALUResultM;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      MemFaultW  <= faultM;
    end
  end

  assign ResultW = ResultSrcW ? ReadDataW : ALUResultW;

endmodule
